// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if
// Groups the handshake between the ID/EX pipeline register and the iterative
// RV32M multiply/divide unit.
//   master : pipeline side. Drives START, FUNCT3, OPERAND_A and OPERAND_B.
//            Receives RESULT, DONE and BUSYWAIT.
//   slave  : muldiv unit side. Signal directions are the reverse of master.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            START;
  logic [2:0]      FUNCT3;
  logic [XLEN-1:0] OPERAND_A;
  logic [XLEN-1:0] OPERAND_B;
  logic [XLEN-1:0] RESULT;
  logic            DONE;
  logic            BUSYWAIT;

  modport master (
    output START, FUNCT3, OPERAND_A, OPERAND_B,
    input  RESULT, DONE, BUSYWAIT
  );

  modport slave (
    input  START, FUNCT3, OPERAND_A, OPERAND_B,
    output RESULT, DONE, BUSYWAIT
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
// Iterative RV32M multiply/divide unit for the EX stage. It processes one bit
// per cycle and has a fixed latency of 33 cycles from START to DONE.
//   CLK      : clock. All state updates on the rising edge.
//   RESET    : synchronous, active-high reset.
//   bus      : slave modport of ex_muldiv_unit_if.
//              - START, FUNCT3, OPERAND_A, OPERAND_B come from ID/EX.
//              - RESULT and DONE are registered and are valid in FIN only.
//              - BUSYWAIT is a combinational stall request.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  ex_muldiv_unit_if.slave bus
);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  state_t          state_r;
  logic [5:0]      cnt_r;
  logic [2:0]      funct3_r;
  logic [XLEN-1:0] a_raw_r;      // original rs1, returned for REM by zero
  logic [XLEN-1:0] mcand_r;      // multiplicand magnitude (mul) or divisor magnitude (div)
  logic [XLEN-1:0] hi_r;         // product high half
  logic [XLEN-1:0] lo_r;         // multiplier/product low half, or dividend/quotient
  logic [32:0]     rem_r;        // partial remainder
  logic            neg_q_r;      // product/quotient sign
  logic            neg_r_r;      // remainder sign
  logic            div_zero_r;
  logic            div_ovf_r;
  logic [XLEN-1:0] result_r;
  logic            done_r;

  logic            sign_a_s;
  logic            sign_b_s;
  logic [XLEN-1:0] mag_a_s;
  logic [XLEN-1:0] mag_b_s;
  logic [32:0]     mul_sum_s;
  logic [XLEN-1:0] mul_hi_nxt_s;
  logic [XLEN-1:0] mul_lo_nxt_s;
  logic [33:0]     div_diff_s;
  logic            div_ge_s;
  logic [32:0]     div_rem_nxt_s;
  logic [XLEN-1:0] div_q_nxt_s;
  logic [63:0]     prod_raw_s;
  logic [63:0]     prod_s;
  logic [XLEN-1:0] quo_s;
  logic [XLEN-1:0] rem_out_s;
  logic [XLEN-1:0] final_s;

  // Select the operand signedness for the incoming instruction and form the magnitudes.
  always_comb begin
    sign_a_s = 1'b0;
    sign_b_s = 1'b0;
    case (bus.FUNCT3)
      F3_MULH, F3_DIV, F3_REM: begin
        sign_a_s = bus.OPERAND_A[31];
        sign_b_s = bus.OPERAND_B[31];
      end
      F3_MULHSU: begin
        sign_a_s = bus.OPERAND_A[31];
        sign_b_s = 1'b0;
      end
      default: begin
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
      end
    endcase
    mag_a_s = sign_a_s ? neg32(bus.OPERAND_A) : bus.OPERAND_A;
    mag_b_s = sign_b_s ? neg32(bus.OPERAND_B) : bus.OPERAND_B;
  end

  // Compute one iteration of the shift-add multiply and of the restoring divide.
  always_comb begin
    // The carry out of the add shifts into HI[31]. The consumed multiplier bit leaves LO[0].
    mul_sum_s    = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mcand_r} : 33'd0);
    mul_hi_nxt_s = mul_sum_s[32:1];
    mul_lo_nxt_s = {mul_sum_s[0], lo_r[31:1]};
    // Shift the next dividend bit into the remainder, then trial-subtract the divisor.
    // Bit 33 of the difference is the borrow.
    div_diff_s    = {rem_r, lo_r[31]} - {2'b00, mcand_r};
    div_ge_s      = ~div_diff_s[33];
    div_rem_nxt_s = div_ge_s ? div_diff_s[32:0] : {rem_r[31:0], lo_r[31]};
    div_q_nxt_s   = {lo_r[30:0], div_ge_s};
  end

  // Form the final result from the last iteration's values. It is registered on entry to FIN.
  always_comb begin
    prod_raw_s = {mul_hi_nxt_s, mul_lo_nxt_s};
    prod_s     = neg_q_r ? neg64(prod_raw_s) : prod_raw_s;
    quo_s      = neg_q_r ? neg32(div_q_nxt_s) : div_q_nxt_s;
    rem_out_s  = neg_r_r ? neg32(div_rem_nxt_s[31:0]) : div_rem_nxt_s[31:0];
    case (funct3_r)
      F3_MUL:                       final_s = prod_s[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_s = prod_s[63:32];
      F3_DIV, F3_DIVU: begin
        if (div_zero_r) begin
          final_s = 32'hFFFF_FFFF;
        end else if (div_ovf_r) begin
          final_s = 32'h8000_0000;
        end else begin
          final_s = quo_s;
        end
      end
      F3_REM, F3_REMU: begin
        if (div_zero_r) begin
          final_s = a_raw_r;
        end else if (div_ovf_r) begin
          final_s = 32'h0000_0000;
        end else begin
          final_s = rem_out_s;
        end
      end
      default:                      final_s = 32'h0000_0000;
    endcase
  end

  // Control FSM with the operand latch, the iteration datapath and the registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 6'd0;
      funct3_r   <= 3'd0;
      a_raw_r    <= 32'd0;
      mcand_r    <= 32'd0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      rem_r      <= 33'd0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      div_zero_r <= 1'b0;
      div_ovf_r  <= 1'b0;
      result_r   <= 32'd0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          result_r <= 32'd0;
          done_r   <= 1'b0;
          if (bus.START) begin
            state_r    <= ST_RUN;
            cnt_r      <= 6'd0;
            funct3_r   <= bus.FUNCT3;
            a_raw_r    <= bus.OPERAND_A;
            // Division keeps the dividend in LO and the divisor as the subtrahend.
            mcand_r    <= bus.FUNCT3[2] ? mag_b_s : mag_a_s;
            lo_r       <= bus.FUNCT3[2] ? mag_a_s : mag_b_s;
            hi_r       <= 32'd0;
            rem_r      <= 33'd0;
            neg_q_r    <= sign_a_s ^ sign_b_s;
            neg_r_r    <= sign_a_s;
            div_zero_r <= (bus.OPERAND_B == 32'd0);
            div_ovf_r  <= ((bus.FUNCT3 == F3_DIV) || (bus.FUNCT3 == F3_REM)) &&
                          (bus.OPERAND_A == 32'h8000_0000) && (bus.OPERAND_B == 32'hFFFF_FFFF);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          cnt_r <= cnt_r + 6'd1;
          if (funct3_r[2]) begin
            rem_r <= div_rem_nxt_s;
            lo_r  <= div_q_nxt_s;
          end else begin
            hi_r <= mul_hi_nxt_s;
            lo_r <= mul_lo_nxt_s;
          end
          if (cnt_r == 6'(ITERS - 1)) begin
            state_r  <= ST_FIN;
            result_r <= final_s;
            done_r   <= 1'b1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FIN: begin
          // START is still high for this same instruction, so it must not re-issue.
          state_r  <= ST_IDLE;
          result_r <= 32'd0;
          done_r   <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          result_r <= 32'd0;
          done_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RESULT   = result_r;
  assign bus.DONE     = done_r;
  assign bus.BUSYWAIT = ~RESET & (((state_r == ST_IDLE) & bus.START) | (state_r == ST_RUN));

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit
// Directed self-checking bench for ex_muldiv_unit. It checks:
//   - the reset state;
//   - multiply and divide results;
//   - the divide special cases;
//   - abort by RESET;
//   - back-to-back issue.
// In every operation the bench also checks the BUSYWAIT/DONE cycle pattern.
module tb_ex_muldiv_unit;

  logic CLK = 1'b0;
  logic RESET;

  ex_muldiv_unit_if #(.XLEN(32)) bus ();

  ex_muldiv_unit #(.XLEN(32), .ITERS(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Observed per-cycle pattern of the last issued operation. Cycle 0 is the START cycle.
  logic [33:0] busy_v;
  logic [33:0] done_v;
  logic [31:0] res_v;
  logic [31:0] idle_res_or;

  localparam logic [33:0] BUSY_EXP = 34'h1_FFFF_FFFF;  // cycles 0..32
  localparam logic [33:0] DONE_EXP = 34'h2_0000_0000;  // cycle 33 only

  // Drive one instruction and record cycles 0..33. Operands and FUNCT3 are
  // scrambled during RUN. Returns just after the FIN edge (cycle 34) with START low.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.START     = 1'b1;
    bus.FUNCT3    = f;
    bus.OPERAND_A = a;
    bus.OPERAND_B = b;
    busy_v      = 34'd0;
    done_v      = 34'd0;
    res_v       = 32'd0;
    idle_res_or = 32'd0;
    for (int cyc = 0; cyc < 34; cyc++) begin
      @(negedge CLK);
      busy_v[cyc] = bus.BUSYWAIT;
      done_v[cyc] = bus.DONE;
      if (bus.DONE) res_v = bus.RESULT;
      else idle_res_or = idle_res_or | bus.RESULT;
      if (cyc >= 1 && cyc <= 32) begin
        bus.OPERAND_A = $urandom;
        bus.OPERAND_B = $urandom;
        bus.FUNCT3    = 3'($urandom_range(0, 7));
      end
      @(posedge CLK);
      #1;
    end
    bus.START = 1'b0;
  endtask

  task automatic test_reset();
    RESET         = 1'b1;
    bus.START     = 1'b1;
    bus.FUNCT3    = 3'b000;
    bus.OPERAND_A = 32'd3;
    bus.OPERAND_B = 32'd4;
    @(negedge CLK);
    checks++;
    if (bus.BUSYWAIT !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_forced: got %b expected 0", bus.BUSYWAIT);
    end
    checks++;
    if (bus.DONE !== 1'b0 || bus.RESULT !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: DONE=%b RESULT=%h expected 0/00000000", bus.DONE, bus.RESULT);
    end
    @(posedge CLK);
    #1;
    RESET     = 1'b0;
    bus.START = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.BUSYWAIT !== 1'b0 || bus.DONE !== 1'b0 || bus.RESULT !== 32'd0) begin
      failures++;
      $display("FAIL idle_after_reset: BUSYWAIT=%b DONE=%b RESULT=%h expected 0/0/0",
               bus.BUSYWAIT, bus.DONE, bus.RESULT);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_mul();
    logic [2:0]  f_t [5];
    logic [31:0] a_t [5];
    logic [31:0] b_t [5];
    logic [31:0] e_t [5];
    f_t = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b001};
    a_t = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    b_t = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
    e_t = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      issue(f_t[i], a_t[i], b_t[i]);
      checks++;
      if (res_v !== e_t[i]) begin
        failures++;
        $display("FAIL mul_result[%0d] f3=%b: got %h expected %h", i, f_t[i], res_v, e_t[i]);
      end
      checks++;
      if (busy_v !== BUSY_EXP) begin
        failures++;
        $display("FAIL mul_busy[%0d]: got %h expected %h", i, busy_v, BUSY_EXP);
      end
      checks++;
      if (done_v !== DONE_EXP) begin
        failures++;
        $display("FAIL mul_done[%0d]: got %h expected %h", i, done_v, DONE_EXP);
      end
      checks++;
      if (idle_res_or !== 32'd0) begin
        failures++;
        $display("FAIL mul_result_idle[%0d]: got %h expected 00000000", i, idle_res_or);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f_t [12];
    logic [31:0] a_t [12];
    logic [31:0] b_t [12];
    logic [31:0] e_t [12];
    f_t = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b101, 3'b111,
            3'b101, 3'b110, 3'b100, 3'b110};
    a_t = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    b_t = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
            32'h8000_0001, 32'h8000_0001, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    e_t = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1,
            32'd1, 32'h7FFF_FFFE, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 12; i++) begin
      issue(f_t[i], a_t[i], b_t[i]);
      checks++;
      if (res_v !== e_t[i]) begin
        failures++;
        $display("FAIL div_result[%0d] f3=%b: got %h expected %h", i, f_t[i], res_v, e_t[i]);
      end
      checks++;
      if (done_v !== DONE_EXP || busy_v !== BUSY_EXP) begin
        failures++;
        $display("FAIL div_timing[%0d]: done=%h busy=%h expected %h/%h",
                 i, done_v, busy_v, DONE_EXP, BUSY_EXP);
      end
    end
  endtask

  task automatic test_abort();
    int done_seen;
    bus.START     = 1'b1;
    bus.FUNCT3    = 3'b000;
    bus.OPERAND_A = 32'd11;
    bus.OPERAND_B = 32'd13;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
    end
    // Cycle 10 (in RUN): the pipeline is flushed and reset at the same time.
    RESET     = 1'b1;
    bus.START = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.BUSYWAIT !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy_forced: got %b expected 0", bus.BUSYWAIT);
    end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.BUSYWAIT !== 1'b0 || bus.DONE !== 1'b0 || bus.RESULT !== 32'd0) begin
      failures++;
      $display("FAIL abort_idle: BUSYWAIT=%b DONE=%b RESULT=%h expected 0/0/0",
               bus.BUSYWAIT, bus.DONE, bus.RESULT);
    end
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.DONE === 1'b1 || bus.BUSYWAIT === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d active cycles expected 0", done_seen);
    end
    @(posedge CLK);
    #1;
    issue(3'b000, 32'd6, 32'd7);
    checks++;
    if (res_v !== 32'd42 || done_v !== DONE_EXP) begin
      failures++;
      $display("FAIL abort_restart: result=%h done=%h expected 0000002a/%h", res_v, done_v, DONE_EXP);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res1;
    logic [33:0] done1;
    logic [33:0] busy1;
    issue(3'b101, 32'd9, 32'd3);
    res1  = res_v;
    done1 = done_v;
    busy1 = busy_v;
    issue(3'b000, 32'd4, 32'd5);
    checks++;
    if (res1 !== 32'd3) begin
      failures++;
      $display("FAIL b2b_first_result: got %h expected 00000003", res1);
    end
    checks++;
    if (res_v !== 32'd20) begin
      failures++;
      $display("FAIL b2b_second_result: got %h expected 00000014", res_v);
    end
    checks++;
    if (done1 !== DONE_EXP || done_v !== DONE_EXP) begin
      failures++;
      $display("FAIL b2b_done: got %h/%h expected %h/%h", done1, done_v, DONE_EXP, DONE_EXP);
    end
    checks++;
    if (busy1 !== BUSY_EXP || busy_v !== BUSY_EXP) begin
      failures++;
      $display("FAIL b2b_busy: got %h/%h expected %h/%h", busy1, busy_v, BUSY_EXP, BUSY_EXP);
    end
    // START is low after the second instruction, so the unit must sit idle and not re-issue.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.BUSYWAIT !== 1'b0 || bus.DONE !== 1'b0) begin
        failures++;
        $display("FAIL b2b_idle[%0d]: BUSYWAIT=%b DONE=%b expected 0/0", i, bus.BUSYWAIT, bus.DONE);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
